// File: rtl/stk_ram_ctrl_if.sv
// Command/response handshake bundle for the RAM-backed stack controller.
// The master issues commands and consumes responses; the slave is the controller.
interface stk_ram_ctrl_if #(
    parameter int W = 32
);
    logic         cmd_vld;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_dat;
    logic         cmd_rdy;

    logic         rsp_vld;
    logic         rsp_rdy;
    logic [W-1:0] rsp_dat;
    logic         rsp_err;

    modport master (
        output cmd_vld, cmd_op, cmd_dat, rsp_rdy,
        input  cmd_rdy, rsp_vld, rsp_dat, rsp_err
    );

    modport slave (
        input  cmd_vld, cmd_op, cmd_dat, rsp_rdy,
        output cmd_rdy, rsp_vld, rsp_dat, rsp_err
    );
endinterface

// File: rtl/stk_ram_ctrl.sv
// LIFO stack controller keeping its entries in an external single-port RAM.
// One command is in flight at a time; POP waits one extra cycle for RAM read data.
module stk_ram_ctrl #(
    parameter  int W  = 32,
    parameter  int N  = 16,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    stk_ram_ctrl_if.slave bus,
    output logic [AW:0]   occ,
    output logic          full,
    output logic          empty,
    output logic          ram_en,
    output logic          ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [W-1:0]  ram_wdat,
    input  logic [W-1:0]  ram_rdat
);

    localparam logic [1:0]  OP_PUSH = 2'b00;
    localparam logic [1:0]  OP_POP  = 2'b01;
    localparam logic [1:0]  OP_CLR  = 2'b10;
    localparam logic [AW:0] OCC_MAX = N[AW:0];
    localparam logic [AW:0] OCC_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        RD
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic         cmd_rdy;
    logic         accept;
    logic         push_ok;
    logic         push_ovf;
    logic         pop_ok;
    logic         pop_unf;
    logic         do_clr;
    logic         bad_op;
    logic         cmd_fail;

    logic [AW:0]  occ_inc;
    logic [AW:0]  occ_dec;

    logic         rsp_vld_q;
    logic [W-1:0] rsp_dat_q;
    logic         rsp_err_q;

    // A new command may enter only when idle and the response slot is free or draining now.
    assign cmd_rdy = !rst && (state == IDLE) && (!rsp_vld_q || bus.rsp_rdy);
    assign accept  = bus.cmd_vld && cmd_rdy;

    assign full    = (occ == OCC_MAX);
    assign empty   = (occ == '0);
    assign occ_inc = occ + OCC_ONE;
    assign occ_dec = occ - OCC_ONE;

    always_comb begin
        push_ok  = 1'b0;
        push_ovf = 1'b0;
        pop_ok   = 1'b0;
        pop_unf  = 1'b0;
        do_clr   = 1'b0;
        bad_op   = 1'b0;
        if (accept) begin
            case (bus.cmd_op)
                OP_PUSH: begin
                    push_ok  = !full;
                    push_ovf = full;
                end
                OP_POP: begin
                    pop_ok  = !empty;
                    pop_unf = empty;
                end
                OP_CLR:  do_clr = 1'b1;
                default: bad_op = 1'b1;
            endcase
        end
        cmd_fail = push_ovf || pop_unf || bad_op;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop_ok) state_nxt = RD;
            RD:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM strobe is purely combinational from the accepted command; addresses stay below N.
    always_comb begin
        ram_en   = push_ok || pop_ok;
        ram_wen  = push_ok;
        ram_addr = push_ok ? occ[AW-1:0] : occ_dec[AW-1:0];
        ram_wdat = bus.cmd_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else if (do_clr) begin
            occ <= '0;
        end else if (push_ok) begin
            occ <= occ_inc;
        end else if (pop_ok) begin
            occ <= occ_dec;
        end
    end

    // Read data arrives while in RD; every other command answers the cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else if (state == RD) begin
            rsp_vld_q <= 1'b1;
            rsp_dat_q <= ram_rdat;
            rsp_err_q <= 1'b0;
        end else if (accept && !pop_ok) begin
            rsp_vld_q <= 1'b1;
            rsp_dat_q <= '0;
            rsp_err_q <= cmd_fail;
        end else if (bus.rsp_rdy) begin
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end
    end

    assign bus.cmd_rdy = cmd_rdy;
    assign bus.rsp_vld = rsp_vld_q;
    assign bus.rsp_dat = rsp_dat_q;
    assign bus.rsp_err = rsp_err_q;

endmodule

// File: doc/stk_ram_ctrl.md
STK_RAM_CTRL -- requirements
Module: stk_ram_ctrl

Interface
REQ-001 Parameter W, default 32, stack entry width in bits.
REQ-002 Parameter N, default 16, stack depth in entries; power of two, N>=2; AW = clog2(N).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_vld  input  1  command valid.
REQ-006 cmd_op  input  2  opcode: 00 PUSH, 01 POP, 10 CLR, 11 reserved.
REQ-007 cmd_dat  input  W  PUSH data.
REQ-008 cmd_rdy  output  1  command accepted when cmd_vld & cmd_rdy.
REQ-009 rsp_vld  output  1  response valid.
REQ-010 rsp_rdy  input  1  response consumed when rsp_vld & rsp_rdy.
REQ-011 rsp_dat  output  W  POP data, else 0.
REQ-012 rsp_err  output  1  command failed (overflow, underflow, reserved op).
REQ-013 occ  output  AW+1  current stack occupancy, 0..N.
REQ-014 full / empty  output  1 each  occ==N / occ==0.
REQ-015 ram_en  output  1  RAM access strobe toward the simulation RAM instance.
REQ-016 ram_wen  output  1  1 = write, 0 = read; meaningful only with ram_en.
REQ-017 ram_addr  output  AW  RAM entry index.
REQ-018 ram_wdat  output  W  RAM write data.
REQ-019 ram_rdat  input  W  RAM read data, valid exactly one cycle after a read strobe.

Function
REQ-020 The block SHALL keep exactly one command outstanding; states IDLE and RD.
REQ-021 cmd_rdy SHALL equal (state==IDLE) & (!rsp_vld | rsp_rdy).
REQ-022 Accepted PUSH with occ<N: ram_en=1, ram_wen=1, ram_addr=occ[AW-1:0], ram_wdat=cmd_dat combinationally in the accept cycle T; occ+1 at T+1; rsp_vld=1, rsp_err=0, rsp_dat=0 at T+1.
REQ-023 Accepted PUSH with occ==N: no RAM access, occ unchanged; rsp_vld=1, rsp_err=1, rsp_dat=0 at T+1.
REQ-024 Accepted POP with occ>0: ram_en=1, ram_wen=0, ram_addr=occ-1 in cycle T; occ-1 and state RD at T+1; ram_rdat captured at T+1 into rsp_dat; rsp_vld=1, rsp_err=0 at T+2; state IDLE at T+2.
REQ-025 Accepted POP with occ==0: no RAM access; rsp_vld=1, rsp_err=1, rsp_dat=0 at T+1.
REQ-026 Accepted CLR: occ=0 at T+1, no RAM access; rsp_vld=1, rsp_err=0, rsp_dat=0 at T+1.
REQ-027 Accepted reserved op: no state change; rsp_vld=1, rsp_err=1, rsp_dat=0 at T+1.
REQ-028 ram_en SHALL be 0 in every cycle without an accepted PUSH/POP as above; ram_wdat and ram_addr are don't-care when ram_en=0.
REQ-029 Response registers SHALL hold stable while rsp_vld & !rsp_rdy; rsp_vld clears the cycle after rsp_rdy unless a new response loads.
REQ-030 A command SHALL be acceptable in the same cycle its predecessor's response is consumed (back-to-back PUSH throughput 1/cycle with rsp_rdy=1; POP throughput 1 per 2 cycles).
REQ-031 occ SHALL never exceed N nor wrap below 0; ram_addr never exceeds N-1.
REQ-032 cmd_dat, cmd_op SHALL be ignored when cmd_vld & cmd_rdy is false.

Reset
REQ-033 While rst=1: state IDLE, occ=0, rsp_vld=0, rsp_dat=0, rsp_err=0, ram_en=0, cmd_rdy=0.
REQ-034 rst during RD SHALL discard the in-flight read; no response SHALL be issued for it.
REQ-035 cmd_rdy SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-036 N=16: PUSH 0xA1,0xB2,0xC3 then POP x3 -> rsp_dat 0xC3,0xB2,0xA1, rsp_err=0, occ 3->0, empty=1.
REQ-037 POP on empty -> rsp_err=1, rsp_dat=0, ram_en never asserted, occ=0.
REQ-038 16 PUSHes of i=0..15 then 17th PUSH 0xFF -> full=1, 17th rsp_err=1, POP returns 0x0F.
REQ-039 rsp_rdy held 0 for 5 cycles after PUSH -> rsp_vld/rsp_err stable, cmd_rdy=0 throughout, next command accepted the cycle rsp_rdy=1.
REQ-040 PUSH 0x11, POP accepted, rst asserted at T+1 -> no rsp_vld after reset, occ=0, cmd_rdy=1 first cycle post-reset.
REQ-041 PUSH x4, CLR, PUSH 0x5A, POP -> CLR rsp_err=0, POP returns 0x5A with ram_addr=0, occ=0.
